hazard_ctrl: RTL

// - Pipeline hazard controller; sole driver of the PC write enable (pc_wrt)
//   and of the IF/ID and ID/EX control strobes.
// - Detects load-use hazards, squashes wrong-path fetches after a taken branch,
//   and freezes the front end while instruction memory is not ready.
// - Sits beside the ID stage: reads ID/EX pipeline fields, drives the PC, IF/ID and ID/EX registers.

---
 rtl/hazard_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: sole driver of pc_wrt and the IF/ID, ID/EX strobes (load-use stall, branch squash, imem-wait freeze).
// Build option: define HAZ_PERF_CNT_EN to build the saturating stall_count counter; otherwise stall_count is tied to 0.
module hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_MAX     = 15,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  output logic             pc_wrt,
  output logic             ifid_wrt,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             imem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int                WAIT_W     = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO  = {WAIT_W{1'b0}};
  localparam logic [1:0]        FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt;
  logic [1:0]        flush_cnt_r;
  logic [1:0]        flush_nxt;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_nxt;
  logic              br_pend_r;
  logic              pend_nxt;
  logic              imem_timeout_r;
  logic              tmo_set_s;
  logic              run_eval_s;
  logic              load_use_s;
  logic              pc_wrt_s;
  logic              ifid_wrt_s;
  logic              ifid_flush_s;
  logic              idex_bubble_s;

  function automatic logic is_load_use(
    input logic             memread,
    input logic [REG_W-1:0] rt_ex,
    input logic [REG_W-1:0] rs_id,
    input logic [REG_W-1:0] rt_id,
    input logic             uses_rt
  );
    return memread & (rt_ex != {REG_W{1'b0}}) &
           ((rt_ex == rs_id) | (uses_rt & (rt_ex == rt_id)));
  endfunction

  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] cnt);
    if (cnt >= WAIT_LAST) begin
      return WAIT_LAST;
    end else begin
      return cnt + WAIT_ONE;
    end
  endfunction

  assign load_use_s = is_load_use(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt);

  // Next-state and Mealy strobes; FLUSH and WAIT-not-ready are resolved here, RUN rules below.
  always_comb begin
    state_nxt     = state_r;
    flush_nxt     = flush_cnt_r;
    wait_nxt      = wait_cnt_r;
    pend_nxt      = br_pend_r;
    tmo_set_s     = 1'b0;
    run_eval_s    = 1'b0;
    pc_wrt_s      = 1'b1;
    ifid_wrt_s    = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;

    case (state_r)
      ST_FLUSH: begin
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
        flush_nxt     = flush_cnt_r - 2'd1;
        if (flush_cnt_r > 2'd1) begin
          state_nxt = ST_FLUSH;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (!imem_ready) begin
          // A branch resolved mid-wait squashes now and is replayed on the ready cycle.
          pc_wrt_s      = 1'b0;
          ifid_wrt_s    = 1'b0;
          ifid_flush_s  = branch_taken;
          idex_bubble_s = 1'b1;
          pend_nxt      = br_pend_r | branch_taken;
          wait_nxt      = wait_inc(wait_cnt_r);
          tmo_set_s     = (wait_inc(wait_cnt_r) == WAIT_LAST);
        end else begin
          run_eval_s = 1'b1;
        end
      end
      ST_RUN: begin
        run_eval_s = 1'b1;
      end
      default: begin
        pc_wrt_s      = 1'b0;
        ifid_wrt_s    = 1'b0;
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
        state_nxt     = ST_RUN;
        flush_nxt     = 2'd0;
        wait_nxt      = WAIT_ZERO;
        pend_nxt      = 1'b0;
      end
    endcase

    if (run_eval_s) begin
      pend_nxt = 1'b0;
      wait_nxt = WAIT_ZERO;
      if (branch_taken | br_pend_r) begin
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = ST_FLUSH;
          flush_nxt = FLUSH_INIT;
        end else begin
          state_nxt = ST_RUN;
          flush_nxt = 2'd0;
        end
      end else if (!imem_ready) begin
        pc_wrt_s      = 1'b0;
        ifid_wrt_s    = 1'b0;
        idex_bubble_s = 1'b1;
        state_nxt     = ST_WAIT;
        wait_nxt      = WAIT_ONE;
        tmo_set_s     = (WAIT_ONE == WAIT_LAST);
      end else if (load_use_s) begin
        // One bubble suffices: it clears ex_memread on the following cycle.
        pc_wrt_s      = 1'b0;
        ifid_wrt_s    = 1'b0;
        idex_bubble_s = 1'b1;
        state_nxt     = ST_RUN;
      end else begin
        state_nxt = ST_RUN;
      end
    end else begin
      run_eval_s = 1'b0;
    end
  end

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_RUN;
      flush_cnt_r    <= 2'd0;
      wait_cnt_r     <= WAIT_ZERO;
      br_pend_r      <= 1'b0;
      imem_timeout_r <= 1'b0;
    end else begin
      state_r        <= state_nxt;
      flush_cnt_r    <= flush_nxt;
      wait_cnt_r     <= wait_nxt;
      br_pend_r      <= pend_nxt;
      imem_timeout_r <= imem_timeout_r | tmo_set_s;
    end
  end

  // Reset forces the front end to hold and squash regardless of state.
  assign pc_wrt       = rst & pc_wrt_s;
  assign ifid_wrt     = rst & ifid_wrt_s;
  assign ifid_flush   = ~rst | ifid_flush_s;
  assign idex_bubble  = ~rst | idex_bubble_s;
  assign imem_timeout = imem_timeout_r;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of post-reset cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!pc_wrt_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;
`else
  assign stall_count = {CNT_W{1'b0}};
`endif

endmodule
